// File: rtl/frog_game_state.sv
// Frog crossing game-rules controller: per-frame collision/goal detection,
// lives, score and the PLAY/HIT/WIN/OVER freeze sequencing for the movers.
module frog_game_state #(
    parameter int PLAYER_SIZE = 32,
    parameter int CAR_WIDTH   = 64,
    parameter int CAR_HEIGHT  = 32,
    parameter int H_DISPLAY   = 640,
    parameter int GOAL_Y      = 32,
    parameter int LIVES       = 3,
    parameter int HIT_FRAMES  = 60,
    parameter int WIN_FRAMES  = 120
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] car_x1,
    input  logic [9:0] car_x2,
    input  logic [9:0] car_x3,
    input  logic [9:0] car_x4,
    input  logic [9:0] car_y1,
    input  logic [9:0] car_y2,
    input  logic [9:0] car_y3,
    input  logic [9:0] car_y4,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       freeze,
    output logic       respawn,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'b00,
        ST_HIT  = 2'b01,
        ST_WIN  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam int MAX_FRAMES = (HIT_FRAMES > WIN_FRAMES) ? HIT_FRAMES : WIN_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0] HIT_LOAD   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD   = CNT_W'(WIN_FRAMES - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
    localparam logic [10:0]      H_LIM      = 11'(H_DISPLAY);
    localparam logic [10:0]      GOAL_LIM   = 11'(GOAL_Y);
    localparam logic [10:0]      PS_W       = 11'(PLAYER_SIZE);
    localparam logic [10:0]      CW_W       = 11'(CAR_WIDTH);
    localparam logic [10:0]      CH_W       = 11'(CAR_HEIGHT);

    state_t           state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic [7:0]       score_q, score_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             respawn_q, respawn_d;
    logic             freeze_q, game_over_q;
    logic             hit, goal;

    // All sums are done in 11 bits so a sprite near the right or bottom edge
    // cannot wrap around and fake an overlap.
    function automatic logic overlap(input logic [9:0] cx, input logic [9:0] cy,
                                     input logic [9:0] px, input logic [9:0] py);
        logic [10:0] cxw, cyw, pxw, pyw;
        cxw = {1'b0, cx};
        cyw = {1'b0, cy};
        pxw = {1'b0, px};
        pyw = {1'b0, py};
        return (cxw < H_LIM) &&
               (pxw < cxw + CW_W) && (cxw < pxw + PS_W) &&
               (pyw < cyw + CH_W) && (cyw < pyw + PS_W);
    endfunction

    always_comb begin
        hit  = overlap(car_x1, car_y1, player_x, player_y) |
               overlap(car_x2, car_y2, player_x, player_y) |
               overlap(car_x3, car_y3, player_x, player_y) |
               overlap(car_x4, car_y4, player_x, player_y);
        goal = ({1'b0, player_y} <= GOAL_LIM);
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        cnt_d     = cnt_q;
        respawn_d = 1'b0;
        unique case (state_q)
            ST_PLAY: begin
                if (frame_tick) begin
                    if (hit) begin
                        if (lives_q <= 2'd1) begin
                            lives_d = 2'd0;
                            state_d = ST_OVER;
                        end else begin
                            lives_d = lives_q - 2'd1;
                            cnt_d   = HIT_LOAD;
                            state_d = ST_HIT;
                        end
                    end else if (goal) begin
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        cnt_d   = WIN_LOAD;
                        state_d = ST_WIN;
                    end
                end
            end
            ST_HIT, ST_WIN: begin
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        respawn_d = 1'b1;
                        state_d   = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    lives_d   = LIVES_INIT;
                    score_d   = 8'd0;
                    respawn_d = 1'b1;
                    state_d   = ST_PLAY;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_PLAY;
            lives_q     <= LIVES_INIT;
            score_q     <= 8'd0;
            cnt_q       <= '0;
            respawn_q   <= 1'b0;
            freeze_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            cnt_q       <= cnt_d;
            respawn_q   <= respawn_d;
            freeze_q    <= (state_d != ST_PLAY);
            game_over_q <= (state_d == ST_OVER);
        end
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign freeze    = freeze_q;
    assign respawn   = respawn_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_frog_game_state.sv
// Scoreboard bench for frog_game_state: stimulus pushes hand-derived expected
// outputs, a negedge monitor pops and compares one cycle after each event.
module tb_frog_game_state;

    localparam logic [1:0] P = 2'b00, H = 2'b01, W = 2'b10, O = 2'b11;

    logic       CLK = 1'b0;
    logic       RST, frame_tick, start;
    logic [9:0] player_x, player_y;
    logic [9:0] car_x1, car_x2, car_x3, car_x4;
    logic [9:0] car_y1, car_y2, car_y3, car_y4;
    logic [1:0] state, lives;
    logic [7:0] score;
    logic       freeze, respawn, game_over;

    always #20 CLK = ~CLK;

    frog_game_state dut (
        .CLK(CLK), .RST(RST), .frame_tick(frame_tick), .start(start),
        .player_x(player_x), .player_y(player_y),
        .car_x1(car_x1), .car_x2(car_x2), .car_x3(car_x3), .car_x4(car_x4),
        .car_y1(car_y1), .car_y2(car_y2), .car_y3(car_y3), .car_y4(car_y4),
        .state(state), .lives(lives), .score(score),
        .freeze(freeze), .respawn(respawn), .game_over(game_over)
    );

    typedef struct {
        logic [14:0] v;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_cur;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic armed   = 1'b0;
    logic chk     = 1'b0;
    logic chk_q   = 1'b0;
    logic evt_q   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Expected word layout: {state, lives, score, freeze, respawn, game_over}.
    function automatic logic [14:0] pack_exp(input logic [1:0] st, input logic [1:0] lv,
                                             input logic [7:0] sc, input logic rs);
        return {st, lv, sc, (st != P), rs, (st == O)};
    endfunction

    task automatic drive(input bit t, input bit s, input bit r, input bit c,
                         input logic [1:0] st, input logic [1:0] lv,
                         input logic [7:0] sc, input logic rs, input string nm);
        @(posedge CLK); #1;
        frame_tick = t;
        start      = s;
        RST        = r;
        chk        = c;
        if (c) sb_q.push_back('{pack_exp(st, lv, sc, rs), nm});
        @(posedge CLK); #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        RST        = 1'b0;
        chk        = 1'b0;
    endtask

    task automatic tick(input bit c, input logic [1:0] st, input logic [1:0] lv,
                        input logic [7:0] sc, input logic rs, input string nm);
        drive(1'b1, 1'b0, 1'b0, c, st, lv, sc, rs, nm);
    endtask

    always @(posedge CLK) begin
        evt_q <= frame_tick | start | RST;
        chk_q <= chk;
    end

    always @(negedge CLK) begin
        if (armed) begin
            if (chk_q) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: got no entry expected one (t=%0t)", $time);
                end else begin
                    e_cur = sb_q.pop_front();
                    check(e_cur.name, {17'd0, state, lives, score, freeze, respawn, game_over},
                          {17'd0, e_cur.v});
                end
            end else if (!evt_q) begin
                check("respawn_idle", {31'd0, respawn}, 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] sat_sc;
        RST = 1'b1; frame_tick = 1'b0; start = 1'b0;
        player_x = 10'd304; player_y = 10'd448;
        car_x1 = 10'd700; car_x2 = 10'd700; car_x3 = 10'd700; car_x4 = 10'd700;
        car_y1 = 10'd320; car_y2 = 10'd200; car_y3 = 10'd160; car_y4 = 10'd96;
        @(posedge CLK); #1;
        armed = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b1, P, 2'd3, 8'd0, 1'b0, "reset");

        for (int i = 0; i < 8; i++) tick(1'b1, P, 2'd3, 8'd0, 1'b0, "idle_play");

        // Edge adjacency and off-screen cars must not collide.
        player_x = 10'd200; player_y = 10'd320;
        car_x1 = 10'd232;
        tick(1'b1, P, 2'd3, 8'd0, 1'b0, "adj_right");
        car_x1 = 10'd136;
        tick(1'b1, P, 2'd3, 8'd0, 1'b0, "adj_left");
        player_x = 10'd620; car_x1 = 10'd640;
        tick(1'b1, P, 2'd3, 8'd0, 1'b0, "h_display");

        // Hit; the car stays on the player through the countdown and is ignored.
        player_x = 10'd200; car_x1 = 10'd200;
        tick(1'b1, H, 2'd2, 8'd0, 1'b0, "hit_entry");
        for (int i = 0; i < 59; i++) tick(1'b1, H, 2'd2, 8'd0, 1'b0, "hit_count");
        tick(1'b1, P, 2'd2, 8'd0, 1'b1, "hit_respawn");
        car_x1 = 10'd700;
        tick(1'b1, P, 2'd2, 8'd0, 1'b0, "post_hit");

        player_x = 10'd100; player_y = 10'd32;
        tick(1'b1, W, 2'd2, 8'd1, 1'b0, "goal_entry");
        for (int i = 0; i < 119; i++) tick(1'b1, W, 2'd2, 8'd1, 1'b0, "win_count");
        tick(1'b1, P, 2'd2, 8'd1, 1'b1, "win_respawn");

        // Goal line and car2 overlap together: hit wins.
        car_x2 = 10'd90; car_y2 = 10'd16;
        tick(1'b1, H, 2'd1, 8'd1, 1'b0, "hit_over_goal");
        for (int i = 0; i < 59; i++) tick(1'b1, H, 2'd1, 8'd1, 1'b0, "hit2_count");
        tick(1'b1, P, 2'd1, 8'd1, 1'b1, "hit2_respawn");
        tick(1'b1, O, 2'd0, 8'd1, 1'b0, "last_life");
        for (int i = 0; i < 3; i++) tick(1'b1, O, 2'd0, 8'd1, 1'b0, "over_hold");
        drive(1'b1, 1'b1, 1'b0, 1'b1, P, 2'd3, 8'd0, 1'b1, "restart");
        car_x2 = 10'd700; player_x = 10'd304; player_y = 10'd448;
        drive(1'b0, 1'b1, 1'b0, 1'b1, P, 2'd3, 8'd0, 1'b0, "start_ignored");

        // Reset during a countdown aborts without a respawn pulse.
        player_x = 10'd200; player_y = 10'd320; car_x1 = 10'd200;
        tick(1'b1, H, 2'd2, 8'd0, 1'b0, "hit3_entry");
        for (int i = 0; i < 10; i++) tick(1'b1, H, 2'd2, 8'd0, 1'b0, "hit3_count");
        car_x1 = 10'd700;
        drive(1'b0, 1'b0, 1'b1, 1'b1, P, 2'd3, 8'd0, 1'b0, "rst_mid_hit");
        tick(1'b1, P, 2'd3, 8'd0, 1'b0, "post_rst");

        // 256 goals in a row: score must stop at 255.
        player_x = 10'd100; player_y = 10'd32;
        for (int k = 1; k <= 256; k++) begin
            sat_sc = (k > 255) ? 8'd255 : 8'(k);
            tick(1'b1, W, 2'd3, sat_sc, 1'b0, "sat_entry");
            for (int i = 0; i < 119; i++) tick(1'b0, W, 2'd3, sat_sc, 1'b0, "");
            tick(k == 256, P, 2'd3, sat_sc, 1'b1, "sat_respawn");
        end

        repeat (3) @(posedge CLK);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
